// File: rtl/pwm_pkg.sv
// Shared constants, pin-mode encoding and the small combinational helpers
// used by the PWM peripheral and its timebase.
package pwm_pkg;

    localparam int PWM_STEPS       = 256;
    localparam int PWM_CNT_W       = 8;
    localparam int NUM_PINS        = 16;
    localparam int PRESCALE_W      = 16;
    localparam int CLK_DIV_DEFAULT = 13;

    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam logic [PWM_CNT_W-1:0] CNT_LAST  = 8'(PWM_STEPS - 1);

    typedef enum logic [1:0] {
        PIN_LOW  = 2'd0,
        PIN_HIGH = 2'd1,
        PIN_PWM  = 2'd2
    } pin_mode_t;

    // Output enable dominates; PWM select only matters for an enabled pin.
    function automatic pin_mode_t pin_mode(input logic en_out, input logic en_pwm);
        pin_mode_t mode;
        if (!en_out) begin
            mode = PIN_LOW;
        end else if (en_pwm) begin
            mode = PIN_PWM;
        end else begin
            mode = PIN_HIGH;
        end
        return mode;
    endfunction

    function automatic logic pin_drive(input pin_mode_t mode, input logic level);
        logic drive;
        case (mode)
            PIN_LOW:  drive = 1'b0;
            PIN_HIGH: drive = 1'b1;
            PIN_PWM:  drive = level;
            default:  drive = 1'b0;
        endcase
        return drive;
    endfunction

    // Full scale is special-cased so 0xFF gives a gap-free 100% output.
    function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
        logic level;
        if (duty == DUTY_FULL) begin
            level = 1'b1;
        end else begin
            level = (cnt < duty);
        end
        return level;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Clock prescaler and 8-bit PWM step counter; emits the step tick and the
// end-of-period wrap strobe.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic [PWM_CNT_W-1:0] o_pwm_cnt,
    output logic                 o_tick,
    output logic                 o_wrap
);

    localparam logic [PRESCALE_W-1:0] DIV_LAST = PRESCALE_W'(CLK_DIV - 1);

    logic [PRESCALE_W-1:0] r_prescale_cnt;
    logic [PWM_CNT_W-1:0]  r_pwm_cnt;
    logic                  w_tick;
    logic                  w_wrap;

    // With CLK_DIV==1 DIV_LAST is zero, so the prescaler idles at 0 and ticks every cycle.
    assign w_tick = (r_prescale_cnt == DIV_LAST);
    assign w_wrap = w_tick && (r_pwm_cnt == CNT_LAST);

    // Prescaler: counts 0..CLK_DIV-1 then wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prescale_cnt <= {PRESCALE_W{1'b0}};
        end else if (w_tick) begin
            r_prescale_cnt <= {PRESCALE_W{1'b0}};
        end else begin
            r_prescale_cnt <= r_prescale_cnt + 16'd1;
        end
    end

    // Step counter: advances once per tick, natural 255->0 wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pwm_cnt <= {PWM_CNT_W{1'b0}};
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_pwm_cnt <= r_pwm_cnt;
        end
    end

    assign o_pwm_cnt = r_pwm_cnt;
    assign o_tick    = w_tick;
    assign o_wrap    = w_wrap;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output block: each pin is low, static high, or driven by a shared
// 8-bit PWM whose duty is shadowed so it only changes at period boundaries.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [7:0]          pwm_duty_cycle,
    output logic [NUM_PINS-1:0] out,
    output logic                period_start
);

    logic [PWM_CNT_W-1:0] w_pwm_cnt;
    logic                 w_tick;
    logic                 w_wrap;
    logic [NUM_PINS-1:0]  w_en_out;
    logic [NUM_PINS-1:0]  w_en_pwm;
    logic                 w_level;
    logic                 w_period_first;
    logic [NUM_PINS-1:0]  w_next_out;

    logic [PWM_CNT_W-1:0] r_duty_shadow;
    logic                 r_step_first;
    logic [NUM_PINS-1:0]  r_out;
    logic                 r_period_start;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .i_clk     (clk),
        .i_rst     (rst),
        .o_pwm_cnt (w_pwm_cnt),
        .o_tick    (w_tick),
        .o_wrap    (w_wrap)
    );

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_level  = pwm_level(w_pwm_cnt, r_duty_shadow);

    // Prescaler sits at 0 exactly in the cycle after a tick (or right after reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_first <= 1'b1;
        end else begin
            r_step_first <= w_tick;
        end
    end

    assign w_period_first = r_step_first && (w_pwm_cnt == 8'd0);

    // Duty shadow: the value present on the wrap cycle becomes live at step 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_shadow <= 8'h00;
        end else if (w_wrap) begin
            r_duty_shadow <= pwm_duty_cycle;
        end else begin
            r_duty_shadow <= r_duty_shadow;
        end
    end

    // Per-pin output mux; enables are not shadowed and apply immediately.
    always_comb begin
        w_next_out = {NUM_PINS{1'b0}};
        for (int i = 0; i < NUM_PINS; i++) begin
            w_next_out[i] = pin_drive(pin_mode(w_en_out[i], w_en_pwm[i]), w_level);
        end
    end

    // Output registers: period_start lines up with out showing step 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out          <= 16'h0000;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_next_out;
            r_period_start <= w_period_first;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule
